muldiv_sequencer: RTL and testbench

//  Multi-cycle signed multiply/divide engine with a start/done handshake.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/booth_r4_recode.sv | 21 ++
 rtl/muldiv_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and iteration helpers for the mul/div sequencer
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN,
    DIV_FIX,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  localparam int DEFAULT_WIDTH = 32;

  // One radix-4 Booth step retires two multiplier bits.
  function automatic int mul_iters(input int width);
    return width / 2;
  endfunction

  // Non-restoring division retires one quotient bit per step.
  function automatic int div_iters(input int width);
    return width;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - start/done request bus between control unit and mul/div engine
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_mul;
  logic             op_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op_mul, op_div, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op_mul, op_div, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/booth_r4_recode.sv
// rtl/booth_r4_recode.sv - radix-4 Booth recoder, 3-bit multiplier window to signed digit
module booth_r4_recode
  import muldiv_pkg::*;
(
  input  logic [2:0]   win,
  output booth_digit_t digit
);

  // Window {b[2i+1], b[2i], b[2i-1]} maps to -2*b[2i+1] + b[2i] + b[2i-1].
  always_comb begin
    digit = ZERO;
    case (win)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle signed Booth multiply / non-restoring divide engine
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  muldiv_sequencer_if.slave  bus
);

  localparam int MUL_ITERS = mul_iters(WIDTH);
  localparam int DIV_ITERS = div_iters(WIDTH);
  localparam int CW        = $clog2(WIDTH);
  localparam int AW        = 2 * WIDTH;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_ITERS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_ITERS - 1);

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      mcand;
  logic [WIDTH:0]     mplier;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic               accept;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  booth_digit_t       digit;
  logic [WIDTH:0]     shifted_rem;
  logic [AW-1:0]      add_x, add_y, sum;
  logic               sub;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
  logic               load_result;

  assign accept = (state == IDLE) && bus.start && (bus.op_mul ^ bus.op_div);
  assign b_zero = (bus.b == '0);
  assign a_mag  = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag  = bus.b[WIDTH-1] ? -bus.b : bus.b;

  assign shifted_rem = {rem[WIDTH-1:0], quo[WIDTH-1]};

  booth_r4_recode u_recode (
    .win   (mplier[2:0]),
    .digit (digit)
  );

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: divide-by-zero short-circuits straight to DONE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.op_mul)  state_n = MUL_RUN;
          else if (b_zero) state_n = DONE;
          else             state_n = DIV_RUN;
        end
      end
      MUL_RUN: if (cnt == MUL_LAST) state_n = DONE;
      DIV_RUN: if (cnt == DIV_LAST) state_n = DIV_FIX;
      DIV_FIX: state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Shared adder operand select: Booth accumulate, remainder add/sub, or final remainder fix.
  always_comb begin
    add_x = '0;
    add_y = '0;
    sub   = 1'b0;
    case (state)
      MUL_RUN: begin
        add_x = acc;
        case (digit)
          POS1:    add_y = mcand;
          POS2:    add_y = {mcand[AW-2:0], 1'b0};
          NEG1: begin add_y = mcand;                  sub = 1'b1; end
          NEG2: begin add_y = {mcand[AW-2:0], 1'b0}; sub = 1'b1; end
          default: add_y = '0;
        endcase
      end
      DIV_RUN: begin
        add_x = {{(WIDTH-1){shifted_rem[WIDTH]}}, shifted_rem};
        add_y = {{WIDTH{1'b0}}, dvsr};
        sub   = ~rem[WIDTH];
      end
      DIV_FIX: begin
        add_x = {{(WIDTH-1){rem[WIDTH]}}, rem};
        add_y = {{WIDTH{1'b0}}, dvsr};
      end
      default: ;
    endcase
    sum = sub ? (add_x - add_y) : (add_x + add_y);
  end

  // Final result formed on the cycle that enters DONE, so hi/lo are valid alongside done.
  always_comb begin
    fin_hi    = '0;
    fin_lo    = '0;
    rem_fixed = rem[WIDTH] ? sum[WIDTH-1:0] : rem[WIDTH-1:0];
    case (state)
      MUL_RUN: {fin_hi, fin_lo} = sum;
      DIV_FIX: begin
        fin_lo = neg_q ? -quo : quo;
        fin_hi = neg_r ? -rem_fixed : rem_fixed;
      end
      IDLE: begin
        fin_lo = '1;
        fin_hi = bus.a;
      end
      default: ;
    endcase
  end

  assign load_result = (state_n == DONE) && (state != DONE);

  // Datapath: operand capture on accept, one iteration per cycle, result latch into hi/lo.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
            mplier <= {bus.b, 1'b0};
            rem    <= '0;
            quo    <= a_mag;
            dvsr   <= b_mag;
            neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r  <= bus.a[WIDTH-1];
            dbz_q  <= bus.op_div && b_zero;
          end
        end
        MUL_RUN: begin
          acc    <= sum;
          mcand  <= {mcand[AW-3:0], 2'b00};
          mplier <= {2'b00, mplier[WIDTH:2]};
          cnt    <= cnt + 1'b1;
        end
        DIV_RUN: begin
          rem <= sum[WIDTH:0];
          quo <= {quo[WIDTH-2:0], ~sum[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
      if (load_result) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for the mul/div sequencer
module tb_muldiv_sequencer;

  logic clock;
  logic clear;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p, sa, sd, q, r;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    e.dbz = 1'b0;
    if (is_mul) begin
      p    = sa * sd;
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.lat = 17;
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      q    = sa / sd;
      r    = sa % sd;
      e.lo = q[31:0];
      e.hi = r[31:0];
      e.lat = 34;
    end
    return e;
  endfunction

  // Caller is at a negedge with the engine idle; returns at the idle negedge after done.
  task automatic run_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                        input int inject, input string tag);
    exp_t e, got;
    int   lat;
    bit   seen;
    e = model(is_mul, a, b);
    sb.push_back(e);
    bus.start  = 1'b1;
    bus.op_mul = is_mul;
    bus.op_div = !is_mul;
    bus.a      = a;
    bus.b      = b;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (lat == 1) begin
        bus.start  = 1'b0;
        bus.op_mul = 1'b0;
        bus.op_div = 1'b0;
        bus.a      = $urandom;
        bus.b      = $urandom;
        if (e.lat > 1) check({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
      end
      if (inject > 0 && lat == inject) begin
        bus.start  = 1'b1;
        bus.op_div = 1'b1;
        bus.a      = $urandom;
        bus.b      = 32'd1;
      end
      if (inject > 0 && lat == inject + 2) begin
        bus.start  = 1'b0;
        bus.op_div = 1'b0;
      end
      seen = bus.done;
    end
    got = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done_within_%0d", tag, got.lat);
      clear = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      return;
    end
    check({tag, "_lat"},  64'(lat), 64'(got.lat));
    check({tag, "_hi"},   64'(bus.hi), 64'(got.hi));
    check({tag, "_lo"},   64'(bus.lo), 64'(got.lo));
    check({tag, "_dbz"},  64'(bus.div_by_zero), 64'(got.dbz));
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
    @(negedge clock);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    clear      = 1'b0;
    bus.start  = 1'b0;
    bus.op_mul = 1'b0;
    bus.op_div = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    check("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    clear = 1'b1;
    @(negedge clock);

    run_op(1'b1, 32'd7,          32'hFFFF_FFFD, 0, "mul_7_m3");
    run_op(1'b1, 32'h8000_0000,  32'h8000_0000, 0, "mul_min_min");
    run_op(1'b1, 32'h7FFF_FFFF,  32'h8000_0000, 0, "mul_max_min");
    run_op(1'b1, 32'd0,          32'h1234_5678, 0, "mul_zero");
    for (int i = 0; i < 4; i++) run_op(1'b1, $urandom, $urandom, 0, "mul_rand");

    run_op(1'b0, 32'hFFFF_FFF9,  32'd2,         0, "div_m7_2");
    run_op(1'b0, 32'd7,          32'hFFFF_FFFE, 0, "div_7_m2");
    run_op(1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 0, "div_m7_m2");
    run_op(1'b0, 32'd100,        32'd7,         0, "div_100_7");
    run_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 0, "div_ovf");
    run_op(1'b0, 32'd5,          32'h8000_0000, 0, "div_small_min");
    for (int i = 0; i < 3; i++) run_op(1'b0, $urandom, $urandom | 32'd1, 0, "div_rand");

    run_op(1'b0, 32'd100, 32'd0, 0, "div0");
    check("dbz_held", 64'(bus.div_by_zero), 64'd1);
    run_op(1'b1, 32'd3, 32'd9, 0, "mul_after_div0");

    bus.start  = 1'b1;
    bus.op_mul = 1'b1;
    bus.op_div = 1'b1;
    bus.a      = 32'd4;
    bus.b      = 32'd4;
    @(negedge clock);
    check("both_ops_ignored", 64'(bus.busy), 64'd0);
    bus.op_mul = 1'b0;
    bus.op_div = 1'b0;
    @(negedge clock);
    check("no_op_ignored", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;

    run_op(1'b1, 32'd11, 32'hFFFF_FFF0, 4, "mul_busy_start");
    run_op(1'b1, 32'd1234, 32'd5678, 0, "mul_back_to_back");

    bus.start  = 1'b1;
    bus.op_div = 1'b1;
    bus.a      = 32'hFFFF_FC18;
    bus.b      = 32'd7;
    @(negedge clock);
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    repeat (10) @(negedge clock);
    clear = 1'b0;
    #1;
    check("clr_busy", 64'(bus.busy), 64'd0);
    check("clr_done", 64'(bus.done), 64'd0);
    check("clr_hi",   64'(bus.hi),   64'd0);
    check("clr_lo",   64'(bus.lo),   64'd0);
    check("clr_dbz",  64'(bus.div_by_zero), 64'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    run_op(1'b1, 32'd5, 32'd6, 0, "mul_after_clear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
